// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_arbiter
//  Description : Two-requester arbiter and sequencer in front of a single-port
//                word load/store unit. M0 (CPU data port) and M1 (debug/DMA
//                loader) share the LSU under round-robin arbitration. M1 can
//                hold ownership for a bounded burst with m1_lock. Each access
//                takes three cycles: IDLE (grant and latch), ACCESS (one LSU
//                cycle), RESP (done pulse and read data).
//  Ports       : clk, rst_n (async, active-low)
//                m0_*/m1_* : req/we/addr/wdata in, gnt/done/rdata out
//                m1_lock   : M1 burst ownership request
//                lsu_*     : we/re/addr/wdata out, rdata in (combinational)
//                Optional (LSU_ARB_STATS_EN): stat_clr in,
//                stat_m0_grants/stat_m1_grants/stat_contention out
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_arbiter #(
    parameter int MAX_LOCK = 8,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] m1_rdata,
    input  logic          m1_lock,
    output logic          lsu_we,
    output logic          lsu_re,
    output logic [AW-1:0] lsu_addr,
    output logic [DW-1:0] lsu_wdata,
    input  logic [DW-1:0] lsu_rdata
`ifdef LSU_ARB_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   stat_m0_grants,
    output logic [15:0]   stat_m1_grants,
    output logic [15:0]   stat_contention
`endif
);

    localparam logic [3:0] c_max_lock = 4'(MAX_LOCK);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_rr;        // 1: M1 preferred on a tie
    logic          r_owner;     // master of the latest grant (1 = M1)
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_lsu_we;
    logic          r_lsu_re;
    logic          r_m0_done;
    logic          r_m1_done;
    logic [3:0]    r_lock_cnt;

    logic          w_idle;
    logic          w_lock_hold;
    logic          w_pref_m1;
    logic          w_sel_m1;
    logic          w_any;
    logic          w_cmd_we;

    assign w_idle = (r_state == S_IDLE);

    // After an M1 grant rr already points at M0, so the lock only has to
    // override rr while the burst budget is not exhausted.
    assign w_lock_hold = r_owner & m1_lock & (r_lock_cnt < c_max_lock);
    assign w_pref_m1   = r_rr | w_lock_hold;
    assign w_sel_m1    = m1_req & (~m0_req | w_pref_m1);
    assign w_any       = w_idle & (m0_req | m1_req);
    assign w_cmd_we    = w_sel_m1 ? m1_we : m0_we;

    assign m0_gnt    = w_idle & m0_req & ~w_sel_m1;
    assign m1_gnt    = w_idle & w_sel_m1;
    assign m0_done   = r_m0_done;
    assign m1_done   = r_m1_done;
    assign m0_rdata  = r_rdata;
    assign m1_rdata  = r_rdata;
    assign lsu_we    = r_lsu_we;
    assign lsu_re    = r_lsu_re;
    assign lsu_addr  = r_addr;
    assign lsu_wdata = r_wdata;

    // Sequencer: LSU strobes and done pulses are registered so that they are
    // high exactly during ACCESS and RESP respectively.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr      <= 1'b0;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_lsu_we  <= 1'b0;
            r_lsu_re  <= 1'b0;
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;
        end else begin
            r_lsu_we  <= 1'b0;
            r_lsu_re  <= 1'b0;
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_we     <= w_cmd_we;
                        r_addr   <= w_sel_m1 ? m1_addr  : m0_addr;
                        r_wdata  <= w_sel_m1 ? m1_wdata : m0_wdata;
                        r_owner  <= w_sel_m1;
                        r_rr     <= ~w_sel_m1;
                        r_lsu_we <= w_cmd_we;
                        r_lsu_re <= ~w_cmd_we;
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Captured for stores too; the value is simply unused.
                    r_rdata   <= lsu_rdata;
                    r_m0_done <= ~r_owner;
                    r_m1_done <= r_owner;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Consecutive M1 grants won while M0 was waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= 4'd0;
        end else if (!m1_lock || m0_gnt) begin
            r_lock_cnt <= 4'd0;
        end else if (m1_gnt && m0_req && (r_lock_cnt < c_max_lock)) begin
            r_lock_cnt <= r_lock_cnt + 4'd1;
        end
    end

`ifdef LSU_ARB_STATS_EN
    logic [15:0] r_stat_m0;
    logic [15:0] r_stat_m1;
    logic [15:0] r_stat_cont;

    assign stat_m0_grants  = r_stat_m0;
    assign stat_m1_grants  = r_stat_m1;
    assign stat_contention = r_stat_cont;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_m0   <= 16'd0;
            r_stat_m1   <= 16'd0;
            r_stat_cont <= 16'd0;
        end else if (stat_clr) begin
            r_stat_m0   <= 16'd0;
            r_stat_m1   <= 16'd0;
            r_stat_cont <= 16'd0;
        end else begin
            if (m0_gnt && (r_stat_m0 != 16'hFFFF)) begin
                r_stat_m0 <= r_stat_m0 + 16'd1;
            end
            if (m1_gnt && (r_stat_m1 != 16'hFFFF)) begin
                r_stat_m1 <= r_stat_m1 + 16'd1;
            end
            if (w_idle && m0_req && m1_req && (r_stat_cont != 16'hFFFF)) begin
                r_stat_cont <= r_stat_cont + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_arbiter
//  Description : Directed self-checking bench for lsu_arbiter with a small
//                word memory model behind the LSU port. Covers single
//                accesses, round-robin ties, M1 burst lock, reset abort and
//                (with LSU_ARB_STATS_EN) the statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_gnt, m0_done;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m1_gnt, m1_done;
    logic [31:0] m1_rdata;
    logic        m1_lock = 1'b0;
    logic        lsu_we, lsu_re;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        stat_clr = 1'b0;
    logic [15:0] stat_m0_grants, stat_m1_grants, stat_contention;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_arbiter #(.MAX_LOCK(8), .AW(32), .DW(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_done   (m0_done),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_done   (m1_done),
        .m1_rdata  (m1_rdata),
        .m1_lock   (m1_lock),
        .lsu_we    (lsu_we),
        .lsu_re    (lsu_re),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_rdata (lsu_rdata)
`ifdef LSU_ARB_STATS_EN
        ,
        .stat_clr        (stat_clr),
        .stat_m0_grants  (stat_m0_grants),
        .stat_m1_grants  (stat_m1_grants),
        .stat_contention (stat_contention)
`endif
    );

`ifndef LSU_ARB_STATS_EN
    assign stat_m0_grants  = '0;
    assign stat_m1_grants  = '0;
    assign stat_contention = '0;
`endif

    // LSU model: 16-word RAM plus a read-only switch register at 0x7800.
    logic [31:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    end
    assign lsu_rdata = (lsu_addr == 32'h7800) ? 32'h0000A5A5 : mem[lsu_addr[5:2]];
    always @(posedge clk) begin
        if (lsu_we) mem[lsu_addr[5:2]] <= lsu_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_gnt",   {m0_gnt, m1_gnt}, 2'b00);
        check("rst_done",  {m0_done, m1_done}, 2'b00);
        check("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
        check("rst_lsu",   {lsu_we, lsu_re, lsu_addr, lsu_wdata}, 66'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full access by master m; checks every cycle of the 3-cycle sequence.
    task automatic do_access(input int m, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        if (m == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
        @(negedge clk);
        check("acc_gnt", {m0_gnt, m1_gnt}, (m == 0) ? 2'b10 : 2'b01);
        check("acc_idle_lsu", {lsu_we, lsu_re}, 2'b00);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        check("acc_lsu_strobe", {lsu_we, lsu_re}, {we, ~we});
        check("acc_lsu_addr", lsu_addr, addr);
        if (we) check("acc_lsu_wdata", lsu_wdata, wdata);
        check("acc_early_done", {m0_done, m1_done}, 2'b00);
        @(negedge clk);
        check("acc_done", {m0_done, m1_done}, (m == 0) ? 2'b10 : 2'b01);
        check("acc_resp_lsu", {lsu_we, lsu_re, m0_gnt, m1_gnt}, 4'b0000);
        if (!we) check("acc_rdata", (m == 0) ? m0_rdata : m1_rdata, exp_rd);
    endtask

    // Both masters request continuously; exp[i]=1 means grant i goes to M1.
    task automatic run_ties(input int n, input logic [15:0] exp);
        @(posedge clk); #1;
        m0_req = 1'b1; m1_req = 1'b1;
        m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = 32'h2004; m1_addr = 32'h7800;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("tie_gnt%0d", i), {m0_gnt, m1_gnt}, exp[i] ? 2'b01 : 2'b10);
            if (i == n - 1) begin
                @(posedge clk); #1;
                m0_req = 1'b0; m1_req = 1'b0;
            end
            @(negedge clk);
            @(negedge clk);
            check($sformatf("tie_done%0d", i), {m0_done, m1_done}, exp[i] ? 2'b01 : 2'b10);
        end
    endtask

    initial begin
        logic done_seen;

        // Test 1: M0 store then load back.
        do_reset();
        do_access(0, 1'b1, 32'h2004, 32'hDEADBEEF, 32'h0);
        do_access(0, 1'b0, 32'h2004, 32'h0, 32'hDEADBEEF);

        // Test 2: round-robin ties from reset.
        do_reset();
        run_ties(4, 16'b1010);

        // Test 3: M1 lock burst after an M0 grant leaves rr on M1.
        do_reset();
        do_access(0, 1'b0, 32'h2004, 32'h0, 32'hDEADBEEF);
        m1_lock = 1'b1;
        run_ties(10, 16'b10_1111_1111);
        m1_lock = 1'b0;

        // Test 4: M1 load of the switch register.
        do_access(1, 1'b0, 32'h7800, 32'h0, 32'h0000A5A5);

        // Test 5: reset asserted mid-ACCESS.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h2008; m0_wdata = 32'h12345678;
        @(negedge clk);
        check("abort_gnt", m0_gnt, 1'b1);
        @(posedge clk); #1;
        m0_req = 1'b0;
        check("abort_in_access", lsu_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_async_clear", {lsu_we, lsu_re, lsu_addr, lsu_wdata, m0_done, m1_done}, 68'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            done_seen = done_seen | m0_done | m1_done;
        end
        check("abort_no_done", done_seen, 1'b0);
        do_access(0, 1'b0, 32'h2004, 32'h0, 32'hDEADBEEF);

`ifdef LSU_ARB_STATS_EN
        // Test 6: statistics. rr now prefers M1, so ties go M1, M0, M1.
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("stat_after_clr0", {stat_m0_grants, stat_m1_grants, stat_contention}, 48'h0);
        run_ties(3, 16'b101);
        for (int i = 0; i < 9; i++) do_access(0, 1'b0, 32'h2004, 32'h0, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) do_access(1, 1'b0, 32'h7800, 32'h0, 32'h0000A5A5);
        @(negedge clk);
        check("stat_m0", stat_m0_grants, 16'd10);
        check("stat_m1", stat_m1_grants, 16'd5);
        check("stat_cont", stat_contention, 16'd3);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("stat_clr", {stat_m0_grants, stat_m1_grants, stat_contention}, 48'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
